// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and sizing helper for the
// sequential logic unit.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width: ceil(log2(n)), never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_slice.sv
// One SLICE-bit chunk of the bitwise operation plus its all-zero flag.
module logic_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s,
    output logic             y_zero
);

    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            default: y_s = ~(a_s | b_s);
        endcase
    end

    assign y_zero = (y_s == '0);

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: accepts WIDTH-bit operands, evaluates one
// SLICE-bit chunk per clock, then presents result and zero flag until taken.
module seq_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zacc_q, zacc_d;
    logic             zero_q;

    logic [SLICE-1:0] a_s, b_s, y_s;
    logic             y_zero;

    assign a_s = a_q[idx_q*SLICE +: SLICE];
    assign b_s = b_q[idx_q*SLICE +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op     (op_q),
        .a_s    (a_s),
        .b_s    (b_s),
        .y_s    (y_s),
        .y_zero (y_zero)
    );

    always_comb begin
        result_d = result_q;
        result_d[idx_q*SLICE +: SLICE] = y_s;
        zacc_d = zacc_q & y_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            idx_q    <= '0;
            result_q <= '0;
            zacc_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        idx_q   <= '0;
                        zacc_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    result_q <= result_d;
                    // Index parks on the last slice; the next accept rewinds it.
                    if (idx_q == LAST_IDX) begin
                        zero_q  <= zacc_d;
                        state_q <= DONE;
                    end else begin
                        zacc_q <= zacc_d;
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: 64/16 instance for the main function and
// a 32/32 instance for the single-slice throughput case.
module tb_seq_logic_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [1:0]  op;
    logic [63:0] a, b, result;

    logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_zero;
    logic [1:0]  v1_op;
    logic [31:0] v1_a, v1_b, v1_result;

    seq_logic_unit #(.WIDTH(64), .SLICE(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    seq_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .op(v1_op), .a(v1_a), .b(v1_b), .out_valid(v1_out_valid),
        .out_ready(v1_out_ready), .result(v1_result), .zero(v1_zero)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_r;
        logic        exp_z;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [63:0] va, input logic [63:0] vb);
        @(negedge clk);
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        op = o; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        int acc[$];
        int ov[$];

        vecs[0] = '{2'b00, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F00000F0F0000, 1'b0};
        vecs[1] = '{2'b10, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 64'h0, 1'b1};
        vecs[2] = '{2'b01, 64'h1, 64'h0, 64'h1, 1'b0};
        vecs[3] = '{2'b11, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 1'b1};
        vecs[4] = '{2'b01, 64'h0, 64'h8000000000000000, 64'h8000000000000000, 1'b0};
        vecs[5] = '{2'b10, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_op = 2'b00; v1_a = '0; v1_b = '0;

        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_r);
            check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].exp_z});
            handshake();
            check($sformatf("vec%0d_ready_after", i), {63'd0, in_ready}, 64'd1);
        end

        // NOR with the consumer stalling in DONE
        start_op(2'b11, 64'h0, 64'h0);
        wait_done(lat);
        check("nor_latency", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_result", result, 64'hFFFFFFFFFFFFFFFF);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        handshake();
        check("stall_ready_after", {63'd0, in_ready}, 64'd1);
        check("stall_valid_after", {63'd0, out_valid}, 64'd0);

        // New request presented while BUSY must be ignored
        start_op(2'b00, vecs[0].a, vecs[0].b);
        op = 2'b01; a = '0; b = '0; in_valid = 1'b1;
        wait_done(lat);
        in_valid = 1'b0;
        check("busy_ign_latency", 64'(lat), 64'd4);
        check("busy_ign_result", result, vecs[0].exp_r);
        handshake();
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("busy_ign_single_pulse", 64'(pulses), 64'd0);

        // Asynchronous reset with idx == 2 mid-operation
        start_op(2'b00, vecs[0].a, vecs[0].b);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", {63'd0, in_ready}, 64'd1);
        start_op(2'b01, 64'hF0, 64'h0F);
        wait_done(lat);
        check("abort_or_latency", 64'(lat), 64'd4);
        check("abort_or_result", result, 64'hFF);
        check("abort_or_zero", {63'd0, zero}, 64'd0);
        handshake();

        // Single-slice instance, back-to-back requests with consumer always ready:
        // accept, slice and handshake edges give one accept every N+2 = 3 cycles.
        @(negedge clk);
        v1_op = 2'b10; v1_a = 32'hFFFF0000; v1_b = 32'h0F0F0F0F;
        v1_in_valid = 1'b1; v1_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (v1_in_ready) acc.push_back(c);
            if (v1_out_valid) begin
                ov.push_back(c);
                check("n1_result", {32'd0, v1_result}, 64'hF0F00F0F);
                check("n1_zero", {63'd0, v1_zero}, 64'd0);
            end
        end
        v1_in_valid = 1'b0; v1_out_ready = 1'b0;
        check("n1_accept_count", 64'(acc.size()), 64'd4);
        check("n1_result_count", 64'(ov.size()), 64'd4);
        for (int i = 1; i < acc.size(); i++)
            check("n1_issue_interval", 64'(acc[i] - acc[i-1]), 64'd3);
        for (int i = 0; i < ov.size() && i < acc.size(); i++)
            check("n1_latency", 64'(ov[i] - acc[i]), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
